// File: rtl/char_pkg.sv
// rtl/char_pkg.sv - shared types for the character buffer write path
package char_pkg;

    localparam int CHAR_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FINISH
    } char_store_state_t;

    typedef logic [CHAR_DATA_WIDTH-1:0] char_t;

endpackage

// File: rtl/char_store_if.sv
// rtl/char_store_if.sv - descriptor, character stream, buffer write port and status of char_store
interface char_store_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) ();

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [ADDR_WIDTH-1:0] cfg_start_addr;
    logic [ADDR_WIDTH-1:0] cfg_end_addr;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  done;
    logic                  overflow;
    logic [ADDR_WIDTH:0]   wr_count;

    modport master (
        output cfg_valid, cfg_start_addr, cfg_end_addr,
        output in_valid, in_data, in_last,
        input  cfg_ready, in_ready,
        input  mem_we, mem_addr, mem_wdata,
        input  done, overflow, wr_count
    );

    modport slave (
        input  cfg_valid, cfg_start_addr, cfg_end_addr,
        input  in_valid, in_data, in_last,
        output cfg_ready, in_ready,
        output mem_we, mem_addr, mem_wdata,
        output done, overflow, wr_count
    );

endinterface

// File: rtl/char_store.sv
// rtl/char_store.sv - writes a character stream into a configured region of the character buffer
module char_store
    import char_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    char_store_if.slave   bus
);

    char_store_state_t     state;
    logic [ADDR_WIDTH-1:0] curr_addr;
    logic [ADDR_WIDTH-1:0] end_addr;

    logic                  cfg_ready_q;
    logic                  in_ready_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  done_q;
    logic                  overflow_q;
    logic [ADDR_WIDTH:0]   wr_count_q;

    logic                  cfg_fire;
    logic                  in_fire;
    logic                  region_full;

    assign cfg_fire    = bus.cfg_valid && cfg_ready_q;
    assign in_fire     = bus.in_valid && in_ready_q;
    assign region_full = (curr_addr == end_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            curr_addr   <= '0;
            end_addr    <= '0;
            cfg_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            wr_count_q  <= '0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        curr_addr   <= bus.cfg_start_addr;
                        end_addr    <= bus.cfg_end_addr;
                        wr_count_q  <= '0;
                        overflow_q  <= 1'b0;
                        cfg_ready_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= WRITE;
                    end else begin
                        cfg_ready_q <= 1'b1;
                    end
                end
                WRITE: begin
                    if (in_fire) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= curr_addr;
                        mem_wdata_q <= bus.in_data;
                        wr_count_q  <= wr_count_q + 1'b1;
                        curr_addr   <= curr_addr + 1'b1;
                        // A last beat landing on the final address is a clean finish, not an overrun.
                        if (bus.in_last || region_full) begin
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            overflow_q <= !bus.in_last;
                            state      <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;
    assign bus.wr_count  = wr_count_q;

endmodule
